// File: rtl/wb_ram_arb2.sv
// wb_ram_arb2
// Two-master Wishbone arbiter in front of the 32x512 on-chip RAM slave.
// m0 is the CPU-side master, m1 the DMA-side master. Grants are round-robin
// and are held for the whole bus cycle (CYC high). There is always one idle
// cycle between two grants. A watchdog ends a stalled access with a one-cycle
// error pulse to the granted master. The grant itself is kept after an error.
//
// Ports (x = 0,1):
//   clk_i, rst_i            clock, synchronous active-high reset
//   mx_cyc_i/stb_i/we_i     master x bus cycle, strobe, write enable
//   mx_sel_i, mx_addr_i     master x byte selects and byte address
//   mx_data_i               master x write data
//   mx_data_o               read data to master x (RAM data, valid when acked)
//   mx_ack_o, mx_err_o      ack / timeout error to master x (granted master only)
//   s_cyc_o ... s_data_o    muxed request toward the RAM (all zero when idle)
//   s_data_i, s_ack_i       RAM read data and ack
module wb_ram_arb2 #(
    parameter int AW      = 11,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic [DW-1:0] m0_data_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic [DW-1:0] m1_data_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_addr_o,
    output logic [DW-1:0] s_data_o,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Watchdog fires when the counter sits at this value with STB forwarded
    // and no ack, so the error lands TIMEOUT cycles after STB first went out.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last;       // index of the master granted most recently
    logic       last_nxt;
    logic [7:0] wd_cnt;
    logic       err_pulse;
    logic       wd_hit;

    // Read data goes to both masters unconditionally; only the ack qualifies it.
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the master that did not win last time goes next.
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last) begin
                        state_nxt = GNT0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = GNT1;
                        last_nxt  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                end
            end

            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                // STB is masked during the error cycle so the RAM cannot
                // complete an access the master has just been told failed.
                s_stb_o  = m0_stb_i & ~err_pulse;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                m0_ack_o = s_ack_i;
                m0_err_o = err_pulse;
                if (!m0_cyc_i) begin
                    state_nxt = IDLE;
                end
            end

            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~err_pulse;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                m1_ack_o = s_ack_i;
                m1_err_o = err_pulse;
                if (!m1_cyc_i) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // An ack in the same cycle as the timeout wins: no error is raised.
    assign wd_hit = (state != IDLE) && s_stb_o && !s_ack_i && (wd_cnt == WD_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            last      <= 1'b1;
            wd_cnt    <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            err_pulse <= wd_hit;
            if ((state == IDLE) || !s_stb_o || s_ack_i || wd_hit) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_arb2.sv
module tb_wb_ram_arb2;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mc   [2];
    logic          ms   [2];
    logic          mw   [2];
    logic [3:0]    msel [2];
    logic [AW-1:0] ma   [2];
    logic [DW-1:0] md   [2];

    logic [DW-1:0] mq0, mq1;
    logic          mk0, mk1, me0, me1;

    logic          s_cyc, s_stb, s_we, s_ack;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdat, s_rdat;

    wb_ram_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m0_cyc_i  (mc[0]),
        .m0_stb_i  (ms[0]),
        .m0_we_i   (mw[0]),
        .m0_sel_i  (msel[0]),
        .m0_addr_i (ma[0]),
        .m0_data_i (md[0]),
        .m0_data_o (mq0),
        .m0_ack_o  (mk0),
        .m0_err_o  (me0),
        .m1_cyc_i  (mc[1]),
        .m1_stb_i  (ms[1]),
        .m1_we_i   (mw[1]),
        .m1_sel_i  (msel[1]),
        .m1_addr_i (ma[1]),
        .m1_data_i (md[1]),
        .m1_data_o (mq1),
        .m1_ack_o  (mk1),
        .m1_err_o  (me1),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_addr_o  (s_addr),
        .s_data_o  (s_wdat),
        .s_data_i  (s_rdat),
        .s_ack_i   (s_ack)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- RAM slave model ----------------
    logic [31:0] mem [512];
    int ack_pct = 0;

    initial begin
        s_ack  = 1'b0;
        s_rdat = '0;
        forever begin
            @(posedge clk);
            #2;
            s_rdat = mem[s_addr[10:2]];
            s_ack  = s_stb && (int'($urandom_range(99)) < ack_pct);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (s_cyc && s_stb && s_ack && s_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_sel[b]) mem[s_addr[10:2]][8*b +: 8] = s_wdat[8*b +: 8];
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int   own = -1;    // granted master, -1 when the bus is idle
    int   pref = 0;    // master that wins the next tie
    int   run = 0;     // consecutive cycles of forwarded STB without ack
    bit   errf = 1'b0;
    bit   mvalid = 1'b0;
    bit   exp_ack [2];
    bit   exp_err [2];

    initial begin
        exp_ack = '{1'b0, 1'b0};
        exp_err = '{1'b0, 1'b0};
        forever begin
            logic          e_cyc, e_stb, e_we;
            logic [3:0]    e_sel;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_dat;
            @(negedge clk);
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_sel = '0; e_addr = '0; e_dat = '0;
            if (own >= 0) begin
                e_cyc  = mc[own];
                e_stb  = ms[own] & ~errf;
                e_we   = mw[own];
                e_sel  = msel[own];
                e_addr = ma[own];
                e_dat  = md[own];
            end
            for (int i = 0; i < 2; i++) begin
                exp_ack[i] = mvalid && (own == i) && s_ack;
                exp_err[i] = mvalid && (own == i) && errf;
            end
            if (mvalid) begin
                chk("s_cyc",  64'(s_cyc),  64'(e_cyc));
                chk("s_stb",  64'(s_stb),  64'(e_stb));
                chk("s_we",   64'(s_we),   64'(e_we));
                chk("s_sel",  64'(s_sel),  64'(e_sel));
                chk("s_addr", 64'(s_addr), 64'(e_addr));
                chk("s_data", 64'(s_wdat), 64'(e_dat));
                chk("m0_ack", 64'(mk0), 64'(exp_ack[0]));
                chk("m1_ack", 64'(mk1), 64'(exp_ack[1]));
                chk("m0_err", 64'(me0), 64'(exp_err[0]));
                chk("m1_err", 64'(me1), 64'(exp_err[1]));
                chk("m0_data", 64'(mq0), 64'(s_rdat));
                chk("m1_data", 64'(mq1), 64'(s_rdat));
            end
            // advance the model across the coming rising edge
            if (rst) begin
                own = -1; pref = 0; run = 0; errf = 1'b0; mvalid = 1'b1;
            end else if (mvalid) begin
                if ((own >= 0) && e_stb && !s_ack) run++;
                else run = 0;
                errf = (run == TO);
                if (errf) run = 0;
                if (own >= 0) begin
                    if (!mc[own]) own = -1;
                end else if (mc[0] && mc[1]) begin
                    own = pref; pref = 1 - own;
                end else if (mc[0]) begin
                    own = 0; pref = 1;
                end else if (mc[1]) begin
                    own = 1; pref = 0;
                end
            end
        end
    end

    // ---------------- random masters ----------------
    bit auto_en = 1'b0;
    bit act [2];
    int beats [2];
    int cool [2];
    int started [2];
    int start_pct = 100, cool_max = 0, max_beats = 1, start_limit = 4;
    bit stb_gaps = 1'b0;

    task automatic new_beat(input int i);
        ms[i]   = 1'b1;
        mw[i]   = 1'($urandom);
        msel[i] = 4'($urandom);
        ma[i]   = AW'($urandom);
        md[i]   = $urandom;
    endtask

    initial begin
        act = '{1'b0, 1'b0};
        forever begin
            @(posedge clk);
            #1;
            if (auto_en) begin
                for (int i = 0; i < 2; i++) begin
                    if (act[i]) begin
                        if (exp_ack[i]) begin
                            beats[i]--;
                            if (beats[i] == 0) begin
                                act[i] = 1'b0; mc[i] = 1'b0; ms[i] = 1'b0;
                                cool[i] = int'($urandom_range(cool_max));
                            end else begin
                                new_beat(i);
                            end
                        end else if (exp_err[i]) begin
                            act[i] = 1'b0; mc[i] = 1'b0; ms[i] = 1'b0;
                            cool[i] = int'($urandom_range(cool_max));
                        end else if (stb_gaps) begin
                            ms[i] = ($urandom_range(7) != 0);
                        end
                    end else if (cool[i] > 0) begin
                        cool[i]--;
                    end else if (started[i] < start_limit && int'($urandom_range(99)) < start_pct) begin
                        act[i] = 1'b1; mc[i] = 1'b1; started[i]++;
                        beats[i] = int'($urandom_range(max_beats, 1));
                        new_beat(i);
                    end
                end
            end
        end
    end

    task automatic tick; @(posedge clk); #1; endtask
    task automatic smp;  @(negedge clk); #1; endtask

    task automatic wait_ack(input int i, input string nm);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            smp();
            if ((i == 0) ? mk0 : mk1) found = 1'b1;
            chk("m0_quiet_in_burst", 64'(i == 1 && mk0), 64'(0));
        end
        chk(nm, 64'(found), 64'(1));
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int who [8];
        int when [8];
        int n, k0, k1;
        for (int i = 0; i < 512; i++) mem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
        mem[4] = 32'hDEADBEEF;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mc[i] = 1'b1; ms[i] = 1'b1; mw[i] = 1'b0; msel[i] = 4'hF; md[i] = '0;
        end
        ma[0] = 11'h100; ma[1] = 11'h200;

        // reset with both masters requesting
        repeat (3) smp();
        chk("rst_s_cyc", 64'(s_cyc), 64'(0));
        chk("rst_s_stb", 64'(s_stb), 64'(0));
        chk("rst_s_addr", 64'(s_addr), 64'(0));
        chk("rst_acks_errs", 64'({mk0, mk1, me0, me1}), 64'(0));
        tick(); rst = 1'b0;
        smp();
        chk("post_rst_idle", 64'(s_cyc), 64'(0));
        smp();
        chk("post_rst_gnt_m0", 64'({s_cyc, s_addr}), 64'({1'b1, 11'h100}));
        tick(); mc = '{1'b0, 1'b0}; ms = '{1'b0, 1'b0};
        smp(); smp();

        // m0 single read of 0x010
        ack_pct = 100;
        tick(); mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b0; ma[0] = 11'h010;
        smp();
        chk("rd_s_cyc_late", 64'(s_cyc), 64'(0));
        smp();
        chk("rd_s_cyc", 64'(s_cyc), 64'(1));
        chk("rd_ack", 64'(mk0), 64'(1));
        chk("rd_data", 64'(mq0), 64'(32'hDEADBEEF));
        chk("rd_m1_ack", 64'(mk1), 64'(0));
        tick(); mc[0] = 1'b0; ms[0] = 1'b0;
        smp(); smp();

        // round robin: both masters, 4 single beats each
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        smp();
        act = '{1'b0, 1'b0}; cool = '{0, 0}; started = '{0, 0};
        start_pct = 100; cool_max = 0; max_beats = 1; start_limit = 4; stb_gaps = 1'b0;
        auto_en = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 8; k++) begin
            smp();
            if (mk0 || mk1) begin
                who[n] = mk1 ? 1 : 0; when[n] = k; n++;
            end
        end
        auto_en = 1'b0;
        chk("rr_count", 64'(n), 64'(8));
        for (int k = 0; k < n; k++) chk("rr_order", 64'(who[k]), 64'(k % 2));
        for (int k = 1; k < n; k++) chk("rr_spacing", 64'(when[k] - when[k-1]), 64'(3));
        tick(); mc = '{1'b0, 1'b0}; ms = '{1'b0, 1'b0};
        smp(); smp();

        // m1 3-beat write burst while m0 waits
        tick(); mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b1; msel[1] = 4'hF; ma[1] = 11'h000; md[1] = 32'd1;
        tick(); mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b0; ma[0] = 11'h040;
        for (int b = 0; b < 3; b++) begin
            wait_ack(1, "burst_ack");
            tick();
            if (b < 2) begin
                ma[1] = AW'(4 * (b + 1)); md[1] = 32'(b + 2);
            end else begin
                mc[1] = 1'b0; ms[1] = 1'b0; mw[1] = 1'b0;
            end
        end
        smp();
        chk("burst_release", 64'(s_cyc), 64'(0));
        smp();
        chk("burst_gap_idle", 64'(s_cyc), 64'(0));
        smp();
        chk("burst_then_m0", 64'({s_cyc, s_addr}), 64'({1'b1, 11'h040}));
        chk("burst_mem0", 64'(mem[0]), 64'(1));
        chk("burst_mem1", 64'(mem[1]), 64'(2));
        chk("burst_mem2", 64'(mem[2]), 64'(3));
        tick(); mc[0] = 1'b0; ms[0] = 1'b0;
        smp(); smp();

        // watchdog: RAM never acks
        ack_pct = 0;
        tick(); mc[0] = 1'b1; ms[0] = 1'b1; ma[0] = 11'h020;
        tick(); mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b0; ma[1] = 11'h0A0;
        k0 = -1; k1 = -1;
        for (int k = 0; k < 40 && k1 < 0; k++) begin
            smp();
            if (s_stb && k0 < 0) k0 = k;
            if (me0) begin
                k1 = k;
                chk("to_stb_masked", 64'(s_stb), 64'(0));
            end
        end
        chk("to_seen", 64'(k1 >= 0), 64'(1));
        chk("to_delay", 64'(k1 - k0), 64'(TO));
        tick(); mc[0] = 1'b0; ms[0] = 1'b0;
        smp();
        chk("to_one_cycle", 64'(me0), 64'(0));
        smp();
        chk("to_idle", 64'(s_cyc), 64'(0));
        smp();
        chk("to_then_m1", 64'({s_cyc, s_addr}), 64'({1'b1, 11'h0A0}));

        // reset while m1 is stalled with the counter at 5
        repeat (4) tick();
        tick(); rst = 1'b1; mc[0] = 1'b1; ms[0] = 1'b1;
        smp();
        chk("rst_mid_no_err", 64'(me1), 64'(0));
        tick(); rst = 1'b0;
        smp();
        chk("rst_mid_s_cyc", 64'(s_cyc), 64'(0));
        chk("rst_mid_errs", 64'({me0, me1}), 64'(0));
        smp();
        chk("rst_mid_gnt_m0", 64'({s_cyc, s_addr}), 64'({1'b1, 11'h020}));
        chk("rst_mid_errs2", 64'({me0, me1}), 64'(0));
        tick(); mc = '{1'b0, 1'b0}; ms = '{1'b0, 1'b0};
        smp(); smp();

        // randomized traffic, varying RAM responsiveness and occasional resets
        act = '{1'b0, 1'b0}; cool = '{0, 0}; started = '{0, 0};
        start_pct = 30; cool_max = 3; max_beats = 4; start_limit = 1000000; stb_gaps = 1'b1;
        auto_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            case (c % 5)
                0: ack_pct = 70;
                1: ack_pct = 30;
                2: ack_pct = 100;
                3: ack_pct = 5;
                default: ack_pct = 0;
            endcase
            repeat (250) begin
                tick();
                rst = ($urandom_range(199) == 0);
            end
        end
        smp();
        auto_en = 1'b0;
        tick(); rst = 1'b0; mc = '{1'b0, 1'b0}; ms = '{1'b0, 1'b0};
        repeat (3) smp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
